// File: rtl/common_pkg.sv
// Shared types and constants for the fetch/decode front end.
package common_pkg;

    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [6:0] {
        OPC_LOAD    = 7'h03,
        OPC_ARITH_I = 7'h13,
        OPC_AUIPC   = 7'h17,
        OPC_STORE   = 7'h23,
        OPC_ARITH_R = 7'h33,
        OPC_LUI     = 7'h37,
        OPC_BRANCH  = 7'h63,
        OPC_JALR    = 7'h67,
        OPC_JAL     = 7'h6f,
        OPC_SYSTEM  = 7'h73
    } opcode_t;

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        OUT
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter: sequential +4 advance or word-aligned redirect.
module pc_reg #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inc,
    input  logic            redirect,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target & ~XLEN'(3);
        end else if (inc) begin
            pc <= pc + XLEN'(4);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: single outstanding imem request, squash on redirect,
// registered instruction handed to decode.
module instr_fetch
    import common_pkg::*;
#(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_ready,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [XLEN-1:0]    branch_target,
    output logic               if_valid,
    output logic [XLEN-1:0]    if_pc,
    output logic [INSTR_W-1:0] if_instr,
    output opcode_t            if_opcode
);

    fetch_state_t    state;
    logic            discard;
    logic [XLEN-1:0] pc;
    logic            accept;
    logic            take;

    // imem_req is only ever high in FETCH
    assign accept = imem_req & imem_ready;
    assign take   = (state == WAIT) & imem_rvalid
                  & ~discard & ~branch_taken;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst_n    (rst_n),
        .inc      (take),
        .redirect (branch_taken),
        .target   (branch_target),
        .pc       (pc)
    );

    assign imem_addr = pc;
    assign if_opcode = opcode_t'(if_instr[6:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            discard  <= 1'b0;
            if_valid <= 1'b0;
            if_pc    <= RESET_PC;
            if_instr <= NOP_INSTR;
            imem_req <= 1'b0;
        end else if (branch_taken) begin
            if_valid <= 1'b0;
            if_instr <= NOP_INSTR;
            unique case (state)
                FETCH: begin
                    state    <= accept ? WAIT : FETCH;
                    discard  <= accept;
                    imem_req <= !accept;
                end
                WAIT: begin
                    state    <= imem_rvalid ? FETCH : WAIT;
                    discard  <= !imem_rvalid;
                    imem_req <= imem_rvalid;
                end
                default: begin
                    state    <= FETCH;
                    discard  <= 1'b0;
                    imem_req <= 1'b1;
                end
            endcase
        end else begin
            unique case (state)
                FETCH: begin
                    if (accept) begin
                        state    <= WAIT;
                        imem_req <= 1'b0;
                    end else begin
                        imem_req <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid && discard) begin
                        discard  <= 1'b0;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end else if (imem_rvalid) begin
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                        if_valid <= 1'b1;
                        state    <= OUT;
                    end
                end
                OUT: begin
                    if (!stall) begin
                        if_valid <= 1'b0;
                        if_instr <= NOP_INSTR;
                        state    <= FETCH;
                        imem_req <= 1'b1;
                    end
                end
                default: begin
                    state    <= FETCH;
                    imem_req <= 1'b0;
                end
            endcase
        end
    end

    // A response outside WAIT has no owner and is dropped
    a_rvalid_in_wait: assert property (
        @(posedge clk) disable iff (!rst_n)
        imem_rvalid |-> state == WAIT
    ) else $warning("imem_rvalid outside WAIT dropped");

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch stage directly upstream of the decode/control logic.
- Owns the program counter and issues one instruction-memory request at a time.
- Registers the returned instruction and presents it, with its opcode field, to the control unit and datapath.
- Supports downstream stall and branch redirect, and discards responses that belong to a squashed fetch.

Parameters:
XLEN, 32, address/PC width
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0013, instruction presented while no valid instruction is held (addi x0,x0,0)

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
imem_req  out  1  request to instruction memory
imem_addr  out  XLEN  word-aligned fetch address (bits[1:0]=0)
imem_ready  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid (exactly one per accepted request, >=1 cycle after accept)
imem_rdata  in  32  returned instruction
stall  in  1  downstream not consuming if_instr this cycle
branch_taken  in  1  one-cycle redirect pulse from execute
branch_target  in  XLEN  redirect address
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_pc  out  XLEN  PC of if_instr
if_instr  out  32  fetched instruction
if_opcode  out  opcode_t  if_instr[6:0], cast to the package opcode type

Behaviour:
- Reset (async assert, sync release): pc=RESET_PC, state=FETCH, discard=0, if_valid=0, if_pc=RESET_PC, if_instr=NOP_INSTR, imem_req=0.
- imem_req is 0 while rst_n=0; it first rises in the first cycle after release.
- State FETCH: imem_req=1, imem_addr=pc.
  - imem_ready=1 -> WAIT.
  - imem_req stays high and imem_addr stable until accepted.
- State WAIT: imem_req=0.
  - On imem_rvalid with discard=0: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+4 (mod 2^XLEN, wraps silently) -> OUT.
  - On imem_rvalid with discard=1: drop data, discard<=0 -> FETCH (pc already redirected).
- State OUT: imem_req=0; if_valid=1.
  - stall=1 -> hold all outputs unchanged.
  - stall=0 -> if_valid<=0, if_instr<=NOP_INSTR -> FETCH.
- Latency: request accepted in cycle N, rvalid in cycle N+k (k>=1), if_valid high from cycle N+k+1. Peak throughput is one instruction per 3 cycles.
- branch_taken=1 (any state): pc<=branch_target with bits[1:0] forced to 0, if_valid<=0, if_instr<=NOP_INSTR.
  - In FETCH, not yet accepted: next state FETCH with the new address.
  - In FETCH, accepted the same cycle: discard<=1 -> WAIT.
  - In WAIT without rvalid: discard<=1, stay WAIT.
  - In WAIT with rvalid the same cycle: data dropped -> FETCH.
  - In OUT: -> FETCH regardless of stall.
- Priority: reset > branch_taken > imem_rvalid > stall.
- stall has no effect in FETCH or WAIT; an in-flight request always completes.
- Reset mid-WAIT: state returns to FETCH. A late rvalid for the pre-reset request arriving in FETCH is ignored. Memory is required to be reset together with this block.
- imem_rvalid in FETCH or OUT (protocol violation): ignored; the simulation assertion fires.
- if_opcode is pure combinational decode of the if_instr register; no extra latency.

Decomposition:
- common_pkg gets:
  - fetch_state_t enum {FETCH, WAIT, OUT}
  - NOP_INSTR constant
  - INSTR_W=32
  - opcode_t (existing) reused for if_opcode
- One natural sub-module: pc_reg, holding the PC register with async reset to RESET_PC, +4 increment and redirect mux with alignment.
- FSM, discard flag and output register stay in instr_fetch.

Test Plan:
- Reset release, imem_ready=1, rvalid 1 cycle after accept, rdata=32'h00500093 -> imem_addr 0x0, if_valid high cycle 3 with if_pc=0x0, if_opcode=ARITH-class value 7'h13 path; next imem_addr 0x4.
- Three sequential fetches, zero wait, stall=0 -> if_pc sequence 0x0,0x4,0x8, each if_valid for exactly one cycle.
- imem_ready low 4 cycles, then rvalid after 3-cycle latency -> imem_addr held at 0x4 throughout, no duplicate request, if_valid only after rvalid.
- stall=1 for 5 cycles while in OUT with instr 32'h00002083 -> if_instr, if_pc and if_valid unchanged, no new imem_req; released -> FETCH next cycle.
- branch_taken with branch_target=0x103 while in WAIT, rvalid 2 cycles later -> returned data never appears on if_instr; next imem_addr=0x100.
- rst_n asserted mid-WAIT, then released, stale rvalid arrives -> outputs at reset values, stale data ignored, fetch restarts at RESET_PC.
